// File: rtl/horner_pkg.sv
// Shared definitions for the Horner evaluator control unit.
package horner_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle = 3'd0,
    StInit = 3'd1,
    StMul  = 3'd2,
    StAdd  = 3'd3,
    StLd   = 3'd4,
    StDone = 3'd5
  } state_e;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter that saturates at zero instead of wrapping.
module down_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ldVal,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; decrement is blocked at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = ldVal;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/horner_cu.sv
// Control unit for the iterative Horner polynomial evaluator: sequences the shared
// X/Tmp datapath through INIT, then (MUL x MUL_LAT, ADD, LD) per remaining coefficient.
module horner_cu
  import horner_pkg::*;
#(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             out_ready,
  output logic             busy,
  output logic             ldX,
  output logic             selTmp,
  output logic             ldTmp,
  output logic             mulEn,
  output logic             addEn,
  output logic [CNT_W-1:0] coefAddr,
  output logic             outValid
);

  localparam int unsigned WcntW = $clog2(MUL_LAT) + 1;

  // First iteration addresses coefficient N_TERMS-2; unused when there is a single term.
  localparam logic [CNT_W-1:0] ItStart    = (N_TERMS >= 2) ? CNT_W'(N_TERMS - 2) : '0;
  localparam logic [CNT_W-1:0] AddrTop    = CNT_W'(N_TERMS - 1);
  localparam logic [WcntW-1:0] WaitStart  = WcntW'(MUL_LAT - 1);
  localparam bit               SingleTerm = (N_TERMS == 1);

  state_e state_q, state_d;

  logic             it_ld, it_dec, it_zero;
  logic [CNT_W-1:0] it_cnt;
  logic             w_ld, w_dec, w_zero;
  logic [WcntW-1:0] w_cnt;

  down_counter #(
    .W(CNT_W)
  ) u_it_cnt (
    .clk  (clk),
    .rst  (rst),
    .ld   (it_ld),
    .ldVal(ItStart),
    .dec  (it_dec),
    .cnt  (it_cnt),
    .zero (it_zero)
  );

  down_counter #(
    .W(WcntW)
  ) u_w_cnt (
    .clk  (clk),
    .rst  (rst),
    .ld   (w_ld),
    .ldVal(WaitStart),
    .dec  (w_dec),
    .cnt  (w_cnt),
    .zero (w_zero)
  );

  // Next-state and counter control; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    it_ld   = 1'b0;
    it_dec  = 1'b0;
    w_ld    = 1'b0;
    w_dec   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StInit;
      end
      StInit: begin
        it_ld = 1'b1;
        if (SingleTerm) begin
          state_d = StDone;
        end else begin
          w_ld    = 1'b1;
          state_d = StMul;
        end
      end
      StMul: begin
        if (w_zero) begin
          state_d = StAdd;
        end else begin
          w_dec = 1'b1;
        end
      end
      StAdd: begin
        state_d = StLd;
      end
      StLd: begin
        if (it_zero) begin
          state_d = StDone;
        end else begin
          it_dec  = 1'b1;
          w_ld    = 1'b1;
          state_d = StMul;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      it_ld   = 1'b0;
      it_dec  = 1'b0;
      w_ld    = 1'b0;
      w_dec   = 1'b0;
    end
  end

  // Moore output decode from the current state and iteration counter.
  always_comb begin
    busy     = 1'b0;
    ldX      = 1'b0;
    selTmp   = 1'b0;
    ldTmp    = 1'b0;
    mulEn    = 1'b0;
    addEn    = 1'b0;
    coefAddr = '0;
    outValid = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StInit: begin
        busy     = 1'b1;
        ldX      = 1'b1;
        selTmp   = 1'b1;
        ldTmp    = 1'b1;
        coefAddr = AddrTop;
      end
      StMul: begin
        busy     = 1'b1;
        mulEn    = 1'b1;
        coefAddr = it_cnt;
      end
      StAdd: begin
        busy     = 1'b1;
        addEn    = 1'b1;
        coefAddr = it_cnt;
      end
      StLd: begin
        busy     = 1'b1;
        ldTmp    = 1'b1;
        coefAddr = it_cnt;
      end
      StDone: begin
        busy     = 1'b1;
        outValid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_horner_cu.sv
// Scoreboard bench for horner_cu: three configurations share one input stream; a
// schedule-based model pushes expected per-cycle outputs, a monitor pops and compares.
module tb_horner_cu;

  localparam int unsigned CNT_W = 3;
  localparam int unsigned RW    = 10;
  localparam int unsigned NCFG  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b0;

  logic [NCFG-1:0] busy, ldx, seltmp, ldtmp, mulen, adden, outvalid;
  logic [CNT_W-1:0] coef0, coef1, coef2;

  int n_vec = 0;
  int n_err = 0;

  bit act [NCFG];
  int tcnt [NCFG];

  logic [NCFG*RW-1:0] exp_q [$];

  always #5 clk = ~clk;

  horner_cu #(.N_TERMS(4), .CNT_W(CNT_W), .MUL_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(out_ready),
    .busy(busy[0]), .ldX(ldx[0]), .selTmp(seltmp[0]), .ldTmp(ldtmp[0]),
    .mulEn(mulen[0]), .addEn(adden[0]), .coefAddr(coef0), .outValid(outvalid[0])
  );

  horner_cu #(.N_TERMS(3), .CNT_W(CNT_W), .MUL_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(out_ready),
    .busy(busy[1]), .ldX(ldx[1]), .selTmp(seltmp[1]), .ldTmp(ldtmp[1]),
    .mulEn(mulen[1]), .addEn(adden[1]), .coefAddr(coef1), .outValid(outvalid[1])
  );

  horner_cu #(.N_TERMS(1), .CNT_W(CNT_W), .MUL_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(out_ready),
    .busy(busy[2]), .ldX(ldx[2]), .selTmp(seltmp[2]), .ldTmp(ldtmp[2]),
    .mulEn(mulen[2]), .addEn(adden[2]), .coefAddr(coef2), .outValid(outvalid[2])
  );

  function automatic int cfg_n(int c);
    case (c)
      0: return 4;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_l(int c);
    case (c)
      0: return 1;
      1: return 3;
      default: return 2;
    endcase
  endfunction

  // Cycle offset (from INIT) at which the result becomes valid.
  function automatic int done_at(int c);
    return 1 + (cfg_n(c) - 1) * (cfg_l(c) + 2);
  endfunction

  // Record: {busy, ldX, selTmp, ldTmp, mulEn, addEn, outValid, coefAddr}
  function automatic logic [RW-1:0] dut_rec(int c);
    case (c)
      0: return {busy[0], ldx[0], seltmp[0], ldtmp[0], mulen[0], adden[0], outvalid[0], coef0};
      1: return {busy[1], ldx[1], seltmp[1], ldtmp[1], mulen[1], adden[1], outvalid[1], coef1};
      default:
        return {busy[2], ldx[2], seltmp[2], ldtmp[2], mulen[2], adden[2], outvalid[2], coef2};
    endcase
  endfunction

  // Expected outputs tt cycles after INIT, straight from the Horner schedule.
  function automatic logic [RW-1:0] exp_rec(int n, int l, int tt);
    int k;
    int i;
    int ph;
    if (tt == 0) return {7'b1111000, 3'(n - 1)};
    k = tt - 1;
    if (k >= (n - 1) * (l + 2)) return {7'b1000001, 3'd0};
    i  = n - 2 - k / (l + 2);
    ph = k % (l + 2);
    if (ph < l) return {7'b1000100, 3'(i)};
    if (ph == l) return {7'b1000010, 3'(i)};
    return {7'b1001000, 3'(i)};
  endfunction

  task automatic check(input string name, input int c, input logic [RW-1:0] got,
                       input logic [RW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cfg%0d at %0t: got %b required %b", name, c, $time, got, want);
    end
  endtask

  // Apply one cycle of inputs and push the model's prediction for the next cycle.
  task automatic step(input logic s, input logic a, input logic r, input logic rsn);
    logic [NCFG*RW-1:0] v;
    @(negedge clk);
    start     = s;
    abort     = a;
    out_ready = r;
    rst       = rsn;
    v = '0;
    for (int c = 0; c < NCFG; c++) begin
      if (!rsn) begin
        act[c] = 1'b0;
      end else if (!act[c]) begin
        if (s) begin
          act[c]  = 1'b1;
          tcnt[c] = 0;
        end
      end else if (a) begin
        act[c] = 1'b0;
      end else if ((tcnt[c] >= done_at(c)) && r) begin
        act[c] = 1'b0;
      end else begin
        tcnt[c]++;
      end
      v[c*RW +: RW] = act[c] ? exp_rec(cfg_n(c), cfg_l(c), tcnt[c]) : '0;
    end
    exp_q.push_back(v);
    if (!rsn) begin
      #1;
      for (int c = 0; c < NCFG; c++) check("async_reset", c, dut_rec(c), '0);
    end
  endtask

  // Monitor: after each active edge, compare every DUT against the predicted record.
  initial begin
    logic [NCFG*RW-1:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        for (int c = 0; c < NCFG; c++) check("cycle", c, dut_rec(c), w[c*RW +: RW]);
      end
    end
  end

  initial begin
    for (int c = 0; c < NCFG; c++) begin
      act[c]  = 1'b0;
      tcnt[c] = 0;
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Nominal run with consumer always ready.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Backpressure with start pulses that must be ignored.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) step((i % 3) == 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Abort during the second MUL of the four-term configuration.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (15) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Full run, then abort coinciding with DONE and out_ready.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Reset pulled mid-run, then a clean run.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(2) == 0), ($urandom_range(39) == 0), ($urandom_range(3) != 0),
           ($urandom_range(199) != 0));
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending records, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/horner_cu.md
# horner_cu

Parametrised control unit for the iterative polynomial evaluator (Horner scheme: Tmp <- a[N-1]; Tmp <- Tmp*X + a[i] for i = N-2 down to 0). It drives the shared X/Tmp datapath: load strobes, mux select, coefficient address, and multiplier/adder enables. It also has an iteration counter, a configurable multi-cycle multiplier wait, abort, and a valid/ready result handshake. It replaces the fixed single-iteration controller and sits between the top-level sequencer and the evaluator datapath.

## Interface
- N_TERMS, 4: number of coefficients. Must be at least 1. Iterations = N_TERMS-1.
- CNT_W, 3: width of coefAddr and the iteration counter. Must be at least clog2(N_TERMS).
- MUL_LAT, 1: cycles spent in MUL per iteration. Must be at least 1.
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: begin evaluation. Sampled only in IDLE.
- abort, in, 1: cancel the evaluation in progress. Ignored in IDLE.
- out_ready, in, 1: consumer accepts the result.
- busy, out, 1: high in every state except IDLE.
- ldX, out, 1: load the X register.
- selTmp, out, 1: 1 selects coefficient into Tmp; 0 selects adder output.
- ldTmp, out, 1: load the Tmp register.
- mulEn, out, 1: multiplier enable.
- addEn, out, 1: adder enable.
- coefAddr, out, CNT_W: coefficient memory address.
- outValid, out, 1: Tmp holds the final result.

## Operation
- States (3-bit): IDLE, INIT, MUL, ADD, LD, DONE. Other encodings go to IDLE.
- Outputs are Moore, decoded from the state and counters only. Any output not listed for a state is 0.
- IDLE: coefAddr=0.
  - start=1 -> INIT.
- INIT: ldX=1, selTmp=1, ldTmp=1, coefAddr=N_TERMS-1.
  - Loads itCnt=N_TERMS-2.
  - N_TERMS=1 -> DONE; otherwise -> MUL with wCnt=MUL_LAT-1.
- MUL: mulEn=1, coefAddr=itCnt.
  - wCnt=0 -> ADD; otherwise decrement wCnt and stay in MUL.
- ADD: addEn=1, coefAddr=itCnt -> LD.
- LD: ldTmp=1, selTmp=0, coefAddr=itCnt.
  - itCnt=0 -> DONE.
  - Otherwise decrement itCnt, reload wCnt=MUL_LAT-1, -> MUL.
- DONE: outValid=1, coefAddr=0.
  - Holds until out_ready=1, then -> IDLE.
  - start is ignored in DONE.
- Abort: abort=1 in any state other than IDLE forces IDLE on the next edge, with no outValid. Abort has priority over out_ready and over every other transition.
- Counters never underflow. The decrement is gated by the zero test.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, itCnt=0, wCnt=0, all outputs 0. Takes effect immediately, including mid-evaluation.
- start high at edge k: INIT occupies cycle k+1.
- DONE is entered at cycle k+2+(N_TERMS-1)*(MUL_LAT+2).
- Each iteration is MUL_LAT+2 cycles: MUL×MUL_LAT, ADD, LD.
- outValid with out_ready already high: DONE lasts exactly 1 cycle; IDLE follows on the next cycle.
- start high on the same cycle DONE exits: ignored. A new start must be sampled in IDLE, so the minimum gap between results is one IDLE cycle.
- busy rises the cycle after start is sampled and falls on entry to IDLE.

## Structure
- Shared package horner_pkg holds:
  - the state encoding constants: IDLE=0, INIT=1, MUL=2, ADD=3, LD=4, DONE=5;
  - the state width, 3.
- One sub-module, down_counter:
  - parameter W;
  - ports clk, rst, ld, ldVal, dec, cnt, zero;
  - asynchronous active-low reset to 0.
- down_counter is instantiated twice: itCnt (width CNT_W) and wCnt (width clog2(MUL_LAT)+1).

## Test plan
- Reset mid-run: N_TERMS=4, MUL_LAT=1; start at cycle 0; pull rst low in cycle 5.
  - Immediately state=IDLE and all outputs 0.
  - After release, start -> normal run.
- Nominal run: N_TERMS=4, MUL_LAT=1, start pulse, out_ready=1.
  - INIT at cycle 1 with coefAddr=3.
  - coefAddr=2,1,0 during successive MUL/ADD/LD iterations.
  - outValid at cycle 11 for 1 cycle, then busy=0.
- Multi-cycle multiply: N_TERMS=3, MUL_LAT=3.
  - mulEn high for 3 consecutive cycles per iteration.
  - DONE at cycle 12.
- Degenerate: N_TERMS=1, start.
  - INIT at cycle 1, DONE at cycle 2.
  - mulEn, addEn and selTmp=0 never asserted.
- Backpressure: out_ready=0 for 5 cycles after DONE.
  - outValid held 5 cycles with state stable.
  - start pulses during DONE are ignored.
  - out_ready=1 -> IDLE on the next edge.
- Abort: abort=1 during the second MUL, and again during DONE together with out_ready=1.
  - Both cases: IDLE on the next cycle.
  - No outValid after the first case.
  - A subsequent start runs a full, correct sequence.
